// File: rtl/cosine_pkg.sv
// Shared types and constants for the cosine request arbiter.
// Purely declarative; no logic, no latency, no flow control.
package cosine_pkg;

  localparam int COS_W = 32;
  localparam logic [COS_W-1:0] COS_ONE = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/cosine_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module cosine_rr_pick
  import cosine_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  int               k;

  always_comb begin
    // rot[j] is the request at position ptr+j (mod N_REQ)
    rot = N_REQ'({req, req} >> ptr);
    any = 1'b0;
    k   = 0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        k   = int'(ptr) + j;
      end
    end
    if (k >= N_REQ) k = k - N_REQ;
    idx = PTR_W'(k);
    gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = any && (idx == PTR_W'(i));
    end
  end

endmodule

// File: rtl/cosine_req_arbiter.sv
// Round-robin share of one cosine core; response CORE_LAT+1 cycles after accept, held until resp_ready.
// One request in flight; req_ready only in IDLE. COSINE_ARB_ZERO_BYPASS_EN answers +/-0 in one cycle.
module cosine_req_arbiter
  import cosine_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CORE_LAT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [COS_W*N_REQ-1:0] req_theta,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [COS_W-1:0]       resp_result,
  output logic [COS_W-1:0]       core_theta,
  input  logic [COS_W-1:0]       core_result,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = cnt_w(CORE_LAT);

  state_t           state, state_d;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0] grant, grant_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [COS_W-1:0] core_theta_d, resp_result_d;
  logic [N_REQ-1:0] resp_valid_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic [COS_W-1:0] theta_sel;
  logic [N_REQ-1:0] grant_oh;
  logic [PTR_W-1:0] next_ptr;

  cosine_rr_pick #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    theta_sel = '0;
    grant_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) theta_sel = req_theta[i*COS_W +: COS_W];
      grant_oh[i] = (grant == PTR_W'(i));
    end
  end

  assign next_ptr = (grant == PTR_W'(N_REQ - 1)) ? '0 : grant + PTR_W'(1);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_d       = state;
    rr_ptr_d      = rr_ptr;
    grant_d       = grant;
    cnt_d         = cnt;
    core_theta_d  = core_theta;
    resp_result_d = resp_result;
    resp_valid_d  = resp_valid;
    req_ready     = '0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready    = pick_gnt;
          core_theta_d = theta_sel;
          grant_d      = pick_idx;
          cnt_d        = CNT_W'(CORE_LAT);
          state_d      = ST_WAIT;
`ifdef COSINE_ARB_ZERO_BYPASS_EN
          if (theta_sel[COS_W-2:0] == '0) begin
            resp_result_d = COS_ONE;
            resp_valid_d  = pick_gnt;
            state_d       = ST_RESP;
          end
`endif
        end
      end
      ST_WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        // core_theta has now been stable for CORE_LAT cycles
        if (cnt == CNT_W'(1)) begin
          resp_result_d = core_result;
          resp_valid_d  = grant_oh;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (|(resp_ready & grant_oh)) begin
          resp_valid_d = '0;
          rr_ptr_d     = next_ptr;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // keep the accept strobe low while reset is asserted
    if (!reset_n) req_ready = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      cnt         <= '0;
      core_theta  <= '0;
      resp_result <= '0;
      resp_valid  <= '0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      grant       <= grant_d;
      cnt         <= cnt_d;
      core_theta  <= core_theta_d;
      resp_result <= resp_result_d;
      resp_valid  <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_cosine_req_arbiter.sv
// Directed bench for cosine_req_arbiter with a stub core (theta ^ 32'hA5A5_0000).
// Honours COSINE_ARB_ZERO_BYPASS_EN when choosing zero-theta expectations.
module tb_cosine_req_arbiter;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [127:0] req_theta;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [31:0]  resp_result;
  logic [31:0]  core_theta;
  logic [31:0]  core_result;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] lanes [4];
  int          gidx [8];
  int          gcyc [8];
  int          ngot;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  rready;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_rv;
    logic        exp_busy;
    logic [31:0] exp_res;
    logic [31:0] exp_core;
  } vec_t;

  vec_t tv [8];

  cosine_req_arbiter #(.N_REQ(4), .CORE_LAT(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_theta(req_theta),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_result(resp_result),
    .core_theta(core_theta),
    .core_result(core_result),
    .busy(busy)
  );

  assign core_result = core_theta ^ 32'hA5A5_0000;

  always_comb begin
    for (int i = 0; i < 4; i++) req_theta[i*32 +: 32] = lanes[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Hold valid mask v with resp_ready all ones and record up to n accepts.
  task automatic run_grants(input logic [3:0] v, input int n);
    ngot       = 0;
    req_valid  = v;
    resp_ready = 4'hF;
    for (int c = 0; c < 80 && ngot < n; c++) begin
      #1;
      if (resp_valid != 4'h0 && ngot > 0) begin
        chk("rr_resp_valid", {28'h0, resp_valid}, 32'(4'b0001 << gidx[ngot-1]));
        chk("rr_resp_result", resp_result, lanes[gidx[ngot-1]] ^ 32'hA5A5_0000);
      end
      if (req_ready != 4'h0) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) gidx[ngot] = i;
        gcyc[ngot] = c;
        ngot++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_grant_count", 32'(ngot), 32'(n));
  endtask

  initial begin
    int first;
    logic [31:0] res;
    int exp_first;
    logic [31:0] exp_res;
    int exp2 [5];
    int exp6 [4];

    lanes[0] = 32'h3f80_0000;
    lanes[1] = 32'h4000_0000;
    lanes[2] = 32'h4040_0000;
    lanes[3] = 32'h4080_0000;
    exp2 = '{0, 1, 2, 3, 0};
    exp6 = '{0, 2, 0, 2};

    tv[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tv[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 32'h3f80_0000};
    tv[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 32'h3f80_0000};
    tv[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 32'h3f80_0000};
    tv[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 32'h3f80_0000};
    tv[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 32'h9A25_0000, 32'h3f80_0000};
    tv[6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1, 32'h9A25_0000, 32'h3f80_0000};
    tv[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h9A25_0000, 32'h3f80_0000};

    // reset state
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    @(negedge clk);
    #1;
    chk("rst_req_ready", {28'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {28'h0, resp_valid}, 32'h0);
    chk("rst_resp_result", resp_result, 32'h0);
    chk("rst_core_theta", core_theta, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // single request, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      req_valid  = tv[i].valid;
      resp_ready = tv[i].rready;
      #1;
      chk($sformatf("t1_req_ready[%0d]", i), {28'h0, req_ready}, {28'h0, tv[i].exp_rdy});
      chk($sformatf("t1_resp_valid[%0d]", i), {28'h0, resp_valid}, {28'h0, tv[i].exp_rv});
      chk($sformatf("t1_busy[%0d]", i), {31'h0, busy}, {31'h0, tv[i].exp_busy});
      chk($sformatf("t1_resp_result[%0d]", i), resp_result, tv[i].exp_res);
      chk($sformatf("t1_core_theta[%0d]", i), core_theta, tv[i].exp_core);
      @(negedge clk);
    end

    // all four requesting: 0,1,2,3,0 spaced 6 cycles
    do_reset();
    run_grants(4'b1111, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < ngot) chk($sformatf("t2_grant[%0d]", i), 32'(gidx[i]), 32'(exp2[i]));
      if (i > 0 && i < ngot) chk($sformatf("t2_spacing[%0d]", i), 32'(gcyc[i] - gcyc[i-1]), 32'd6);
    end

    // response held under backpressure
    do_reset();
    req_valid = 4'b0001;
    #1;
    chk("t3_accept", {28'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (resp_valid != 4'h0) begin
        first = c;
        break;
      end
      @(negedge clk);
    end
    chk("t3_resp_seen", {31'h0, first >= 0}, 32'h1);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("t3_hold_resp_valid", {28'h0, resp_valid}, 32'h1);
      chk("t3_hold_resp_result", resp_result, 32'h9A25_0000);
      chk("t3_hold_req_ready", {28'h0, req_ready}, 32'h0);
      chk("t3_hold_busy", {31'h0, busy}, 32'h1);
    end
    resp_ready = 4'b0100;
    @(negedge clk);
    #1;
    chk("t3_foreign_ready_ignored", {28'h0, resp_valid}, 32'h1);
    resp_ready = 4'b0001;
    @(negedge clk);
    resp_ready = '0;
    #1;
    chk("t3_done_resp_valid", {28'h0, resp_valid}, 32'h0);
    chk("t3_done_busy", {31'h0, busy}, 32'h0);
    chk("t3_next_rr", {28'h0, req_ready}, 32'h2);
    req_valid = '0;

    // reset in the middle of WAIT aborts the transaction
    do_reset();
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("t4_core_theta_pre", core_theta, 32'h3f80_0000);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t4_rst_req_ready", {28'h0, req_ready}, 32'h0);
    chk("t4_rst_resp_valid", {28'h0, resp_valid}, 32'h0);
    chk("t4_rst_resp_result", resp_result, 32'h0);
    chk("t4_rst_core_theta", core_theta, 32'h0);
    chk("t4_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t4_no_resp", {28'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    req_valid = 4'b1111;
    #1;
    chk("t4_next_grant", {28'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;

    // zero theta
    do_reset();
    lanes[0]  = 32'h0000_0000;
    req_valid = 4'b0001;
    #1;
    chk("t5_accept", {28'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;
    first = -1;
    res   = '0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (resp_valid[0] && first < 0) begin
        first = c;
        res   = resp_result;
      end
      @(negedge clk);
    end
`ifdef COSINE_ARB_ZERO_BYPASS_EN
    exp_first = 1;
    exp_res   = 32'h8000_0000;
`else
    exp_first = 5;
    exp_res   = 32'hA5A5_0000;
`endif
    chk("t5_latency", 32'(first), 32'(exp_first));
    chk("t5_result", res, exp_res);
    chk("t5_core_theta", core_theta, 32'h0);
    lanes[0] = 32'h3f80_0000;

    // two requesters alternate
    do_reset();
    run_grants(4'b0101, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ngot) chk($sformatf("t6_grant[%0d]", i), 32'(gidx[i]), 32'(exp6[i]));
      if (i > 0 && i < ngot) chk($sformatf("t6_spacing[%0d]", i), 32'(gcyc[i] - gcyc[i-1]), 32'd6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
